// File: rtl/instr_fetch_seq_if.sv
// Instruction fetch bus: instruction RAM read port plus the decoder valid/ready handshake.
// master = fetch sequencer, slave = RAM/decoder side.
interface instr_fetch_seq_if #(
  parameter int unsigned INSTR_WIDTH = 28,
  parameter int unsigned IMEM_AWIDTH = 8
);
  logic                   imem_rd_en;
  logic [IMEM_AWIDTH-1:0] imem_addr;
  logic [INSTR_WIDTH-1:0] imem_rd_data;
  logic [INSTR_WIDTH-1:0] instr_out;
  logic                   instr_valid;
  logic                   instr_ready;

  modport master (
    output imem_rd_en, imem_addr, instr_out, instr_valid,
    input  imem_rd_data, instr_ready
  );

  modport slave (
    input  imem_rd_en, imem_addr, instr_out, instr_valid,
    output imem_rd_data, instr_ready
  );
endinterface

// File: rtl/instr_fetch_seq.sv
// Instruction fetch sequencer: reads words from a synchronous instruction RAM, buffers them in a
// 2-entry FIFO and hands them to the decoder until the first END_CHAIN word is accepted.
// Optional feature macro: INSTR_FETCH_STALL_CNT_EN (builds the decoder stall counter).
module instr_fetch_seq #(
  parameter int unsigned INSTR_WIDTH  = 28,
  parameter int unsigned OPCODE_WIDTH = 4,
  parameter int unsigned IMEM_AWIDTH  = 8,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [IMEM_AWIDTH-1:0] start_addr,
  instr_fetch_seq_if.master      bus,
  output logic                   busy,
  output logic                   done,
  output logic [CNT_WIDTH-1:0]   instr_count,
  output logic [CNT_WIDTH-1:0]   stall_count
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [OPCODE_WIDTH-1:0] END_CHAIN = OPCODE_WIDTH'(12);

  logic [1:0]             state_q, state_d;
  logic [IMEM_AWIDTH-1:0] pc_q;
  logic                   rd_pend_q;
  logic [INSTR_WIDTH-1:0] q0_q, q1_q;
  logic [1:0]             occ_q;

  logic       start_acc, push, pop, rd_en, ret_end;
  logic [2:0] credit;

  assign start_acc = start && (state_q == IDLE);
  assign pop       = (occ_q != 2'd0) && bus.instr_ready;
  // Data returning after DRAIN entry is the overfetched word; it is dropped, not queued.
  assign push      = rd_pend_q && (state_q == RUN);
  assign ret_end   = push && (bus.imem_rd_data[INSTR_WIDTH-1 -: OPCODE_WIDTH] == END_CHAIN);
  // Slots already claimed: queued + in flight, less the entry leaving this cycle.
  assign credit    = {1'b0, occ_q} + {2'b00, rd_pend_q} - {2'b00, pop};
  assign rd_en     = (state_q == RUN) && (credit < 3'd2);

  assign bus.imem_rd_en  = rd_en;
  assign bus.imem_addr   = pc_q;
  assign bus.instr_out   = q0_q;
  assign bus.instr_valid = (occ_q != 2'd0);

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

  // Next-state logic for the sequencing FSM.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (ret_end) state_d = DRAIN;
      // END_CHAIN is the last queued entry, so it leaves when the queue drains to empty.
      DRAIN:   if (pop && (occ_q == 2'd1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state, program counter and in-flight read tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      rd_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_pend_q <= rd_en;
      if (start_acc) begin
        pc_q <= start_addr;
      end else if (rd_en) begin
        pc_q <= pc_q + 1'b1;
      end
    end
  end

  // Two-entry FIFO; q0 is always the oldest entry and drives the decoder.
  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q <= 2'd0;
      q0_q  <= '0;
      q1_q  <= '0;
    end else begin
      case ({push, pop})
        2'b11: begin
          if (occ_q == 2'd1) begin
            q0_q <= bus.imem_rd_data;
          end else begin
            q0_q <= q1_q;
            q1_q <= bus.imem_rd_data;
          end
        end
        2'b01: begin
          q0_q  <= q1_q;
          occ_q <= occ_q - 2'd1;
        end
        2'b10: begin
          if (occ_q == 2'd0) begin
            q0_q <= bus.imem_rd_data;
          end else begin
            q1_q <= bus.imem_rd_data;
          end
          occ_q <= occ_q + 2'd1;
        end
        default: ;
      endcase
    end
  end

  // Saturating count of decoder transfers in the current sequence.
  always_ff @(posedge clk) begin
    if (reset || start_acc) begin
      instr_count <= '0;
    end else if (pop && !(&instr_count)) begin
      instr_count <= instr_count + 1'b1;
    end
  end

`ifdef INSTR_FETCH_STALL_CNT_EN
  // Saturating count of cycles the decoder holds off a valid instruction.
  always_ff @(posedge clk) begin
    if (reset || start_acc) begin
      stall_count <= '0;
    end else if (busy && bus.instr_valid && !bus.instr_ready && !(&stall_count)) begin
      stall_count <= stall_count + 1'b1;
    end
  end
`else
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Self-checking bench for instr_fetch_seq: directed programs in a bench-side RAM, a
// transaction-level model of the expected instruction stream, and hand-computed cycle checks.
module tb_instr_fetch_seq;
  localparam int unsigned IW = 28;
  localparam int unsigned AW = 8;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic          busy, done;
  logic [CW-1:0] instr_count, stall_count;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   t0 = 0;
  logic mon_en = 1'b0;

  logic [IW-1:0] ram [256];

  instr_fetch_seq_if #(.INSTR_WIDTH(IW), .IMEM_AWIDTH(AW)) bus ();

  instr_fetch_seq #(
    .INSTR_WIDTH (IW),
    .OPCODE_WIDTH(4),
    .IMEM_AWIDTH (AW),
    .CNT_WIDTH   (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .start_addr (start_addr),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .instr_count(instr_count),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous instruction RAM: data one cycle after the read strobe.
  always @(posedge clk) if (bus.imem_rd_en) bus.imem_rd_data <= ram[bus.imem_addr];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (rel cycle %0d)", name, act, exp, cyc - t0);
    end
  endtask

  // Model: expected transfer stream, read address sequence, busy/done timing and counters.
  logic [IW-1:0] exp_q[$];
  logic          m_busy = 1'b0, m_done = 1'b0, prev_stall = 1'b0, end_rd_seen = 1'b0;
  logic [IW-1:0] prev_out;
  logic [AW-1:0] m_rd_addr = '0;
  int            m_xfers = 0, m_stalls = 0, m_reads = 0, m_len = 0, end_rd_cyc = 0;
  int            rd_total = 0;

  always @(negedge clk) begin
    logic          xfer, end_xfer;
    logic [AW-1:0] a;
    xfer     = bus.instr_valid && bus.instr_ready;
    end_xfer = 1'b0;
    if (mon_en && !reset) begin
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("instr_count", instr_count, m_xfers);
`ifdef INSTR_FETCH_STALL_CNT_EN
      chk("stall_count", stall_count, m_stalls);
`else
      chk("stall_count", stall_count, 0);
`endif
      if (!m_busy) begin
        chk("idle_valid", bus.instr_valid, 0);
        chk("idle_rd_en", bus.imem_rd_en, 0);
      end
      if (prev_stall) begin
        chk("stall_valid_hold", bus.instr_valid, 1);
        chk("stall_out_hold", bus.instr_out, prev_out);
      end
      if (xfer) begin
        chk("xfer_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) chk("xfer_data", bus.instr_out, exp_q[0]);
      end
      if (bus.imem_rd_en) begin
        chk("rd_addr", bus.imem_addr, m_rd_addr);
        if (end_rd_seen) chk("rd_after_end", cyc, end_rd_cyc + 1);
      end
    end
    if (reset) begin
      exp_q.delete();
      m_busy      = 1'b0;
      m_done      = 1'b0;
      prev_stall  = 1'b0;
      end_rd_seen = 1'b0;
      m_xfers     = 0;
      m_stalls    = 0;
    end else begin
      if (xfer && exp_q.size() > 0) begin
        end_xfer = (exp_q[0][27:24] == 4'hC);
        void'(exp_q.pop_front());
      end
      if (xfer) m_xfers++;
      if (bus.instr_valid && !bus.instr_ready && m_busy) m_stalls++;
      if (bus.imem_rd_en) begin
        if (m_reads == m_len - 1) begin
          end_rd_seen = 1'b1;
          end_rd_cyc  = cyc;
        end
        m_reads++;
        m_rd_addr++;
        rd_total++;
      end
      prev_stall = bus.instr_valid && !bus.instr_ready;
      prev_out   = bus.instr_out;
      if (m_busy) begin
        m_busy = !m_done;
      end else if (start) begin
        exp_q.delete();
        a     = start_addr;
        m_len = 0;
        for (int i = 0; i < 256; i++) begin
          exp_q.push_back(ram[a]);
          m_len++;
          if (ram[a][27:24] == 4'hC) break;
          a++;
        end
        m_busy      = 1'b1;
        m_xfers     = 0;
        m_stalls    = 0;
        m_reads     = 0;
        end_rd_seen = 1'b0;
        m_rd_addr   = start_addr;
      end
      m_done = end_xfer;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one cycle; that cycle is relative cycle 0.
  task automatic launch(input logic [AW-1:0] addr);
    step();
    start      = 1'b1;
    start_addr = addr;
    t0         = cyc;
    step();
    start = 1'b0;
  endtask

  // Move to just after the rising edge that begins relative cycle k.
  task automatic goto_cyc(input int k);
    while (cyc < t0 + k) step();
  endtask

  // Move to the falling edge inside relative cycle k.
  task automatic at_neg(input int k);
    goto_cyc(k);
    @(negedge clk);
  endtask

  task automatic wait_done(input int limit);
    int n;
    n = 0;
    @(negedge clk);
    while (done !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", done, 1);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_rd_en"}, bus.imem_rd_en, 0);
    chk({tag, "_addr"}, bus.imem_addr, 0);
    chk({tag, "_out"}, bus.instr_out, 0);
    chk({tag, "_valid"}, bus.instr_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_icnt"}, instr_count, 0);
    chk({tag, "_scnt"}, stall_count, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r0;
    bus.instr_ready = 1'b1;
    for (int i = 0; i < 256; i++) ram[i] = 28'h1000000 | IW'(i);
    ram[5]   = 28'h4123456;
    ram[6]   = 28'h5234567;
    ram[7]   = 28'h9345678;
    ram[8]   = 28'hC456789;
    ram[9]   = 28'h3ABCDEF;
    ram[255] = 28'h5FF0001;
    ram[0]   = 28'hC000002;
    ram[10]  = 28'hC0A0A0A;
    ram[11]  = 28'h40B0B0B;
    ram[20]  = 28'h1000014;
    ram[21]  = 28'h2000015;
    ram[22]  = 28'h3000016;
    ram[23]  = 28'h4000017;
    ram[24]  = 28'h5000018;
    ram[25]  = 28'hC000019;

    reset = 1'b1;
    repeat (3) step();
    @(negedge clk);
    check_reset("por");
    step();
    reset  = 1'b0;
    mon_en = 1'b1;
    repeat (2) step();

    // Straight-line: 4,5,9,12 from address 5, decoder always ready.
    bus.instr_ready = 1'b1;
    launch(8'd5);
    at_neg(1);
    chk("t1_rd_en_c1", bus.imem_rd_en, 1);
    chk("t1_addr_c1", bus.imem_addr, 5);
    at_neg(2);
    chk("t1_valid_c2", bus.instr_valid, 0);
    at_neg(3);
    chk("t1_valid_c3", bus.instr_valid, 1);
    chk("t1_out_c3", bus.instr_out, 28'h4123456);
    at_neg(6);
    chk("t1_out_c6", bus.instr_out, 28'hC456789);
    at_neg(7);
    chk("t1_done_c7", done, 1);
    chk("t1_busy_c7", busy, 1);
    at_neg(8);
    chk("t1_busy_c8", busy, 0);
    chk("t1_count", instr_count, 4);
    repeat (2) step();

    // Backpressure: decoder not ready in cycles 3..6.
    bus.instr_ready = 1'b0;
    r0 = rd_total;
    launch(8'd5);
    at_neg(6);
    chk("t2_reads", rd_total - r0, 2);
    chk("t2_head", bus.instr_out, 28'h4123456);
    goto_cyc(7);
    bus.instr_ready = 1'b1;
    at_neg(7);
`ifdef INSTR_FETCH_STALL_CNT_EN
    chk("t2_stalls", stall_count, 4);
`else
    chk("t2_stalls", stall_count, 0);
`endif
    at_neg(11);
    chk("t2_done_c11", done, 1);
    at_neg(12);
    chk("t2_count", instr_count, 4);
    repeat (2) step();

    // Address wrap: 255 then 0.
    launch(8'd255);
    at_neg(1);
    chk("t3_addr_c1", bus.imem_addr, 255);
    at_neg(2);
    chk("t3_rd_en_c2", bus.imem_rd_en, 1);
    chk("t3_addr_c2", bus.imem_addr, 0);
    at_neg(5);
    chk("t3_done_c5", done, 1);
    at_neg(6);
    chk("t3_count", instr_count, 2);
    repeat (2) step();

    // Overfetch: END_CHAIN at the start address.
    launch(8'd10);
    at_neg(3);
    chk("t4_rd_en_c3", bus.imem_rd_en, 0);
    chk("t4_out_c3", bus.instr_out, 28'hC0A0A0A);
    at_neg(4);
    chk("t4_done_c4", done, 1);
    chk("t4_rd_en_c4", bus.imem_rd_en, 0);
    at_neg(5);
    chk("t4_count", instr_count, 1);
    repeat (2) step();

    // Reset with a full queue.
    bus.instr_ready = 1'b0;
    launch(8'd20);
    goto_cyc(4);
    reset = 1'b1;
    at_neg(4);
    chk("t5_full_valid", bus.instr_valid, 1);
    goto_cyc(5);
    reset = 1'b0;
    bus.instr_ready = 1'b1;
    at_neg(5);
    check_reset("t5");
    at_neg(7);
    chk("t5_valid_c7", bus.instr_valid, 0);
    repeat (2) step();

    // Reset with a read in flight; the returning word must not be queued.
    launch(8'd20);
    goto_cyc(2);
    reset = 1'b1;
    goto_cyc(3);
    reset = 1'b0;
    at_neg(3);
    chk("t5b_valid_c3", bus.instr_valid, 0);
    at_neg(4);
    chk("t5b_valid_c4", bus.instr_valid, 0);
    repeat (2) step();

    // Clean restart after reset.
    launch(8'd5);
    at_neg(3);
    chk("t5c_out_c3", bus.instr_out, 28'h4123456);
    at_neg(7);
    chk("t5c_done_c7", done, 1);
    repeat (2) step();

    // Start during RUN with another address is ignored.
    launch(8'd5);
    goto_cyc(2);
    start      = 1'b1;
    start_addr = 8'd20;
    goto_cyc(3);
    start = 1'b0;
    at_neg(3);
    chk("t6_out_c3", bus.instr_out, 28'h4123456);
    at_neg(7);
    chk("t6_done_c7", done, 1);
    at_neg(8);
    chk("t6_count", instr_count, 4);
    repeat (2) step();

    // Bounded completion check on a longer program.
    launch(8'd20);
    wait_done(40);
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
